clk_period_meter: RTL and testbench
===================================

# clk_period_meter

Measures the period of a slow, asynchronous square wave in `clk` cycles and classifies it against the four nominal rates of the system clock divider (÷10, ÷50, ÷100, ÷500, i.e. toggle periods of 20/100/200/1000 `clk` cycles). It sits on the receiving side of the divided-clock outputs, where it checks rate and presence on bring-up. A measurement is started by a one-cycle `start` pulse and ends in a one-cycle `valid` pulse, which carries the result, a timeout flag and a class code.

## Interface
- `CNT_W`, 16: width of the period counter and of `period_out`.
- `MAX_PERIOD`, 4096: timeout limit in `clk` cycles per waiting phase; must be ≤ 2^CNT_W − 1.
- `TOL`, 2: classification tolerance in `clk` cycles (±).

- `clk` input 1: system clock, rising-edge.
- `rst` input 1: asynchronous, active-high reset.
- `sig_in` input 1: measured signal, asynchronous to `clk`.
- `start` input 1: one-cycle request to begin a measurement.
- `busy` output 1: high from the cycle after an accepted `start` until the `valid` cycle inclusive.
- `valid` output 1: one-cycle pulse; the result outputs are updated in the same cycle.
- `period_out` output CNT_W: measured period in `clk` cycles; 0 on timeout.
- `timeout` output 1: set with `valid` if no edge arrived within `MAX_PERIOD` cycles.
- `match` output 3: 0 none, 1 ÷10, 2 ÷50, 3 ÷100, 4 ÷500.

## Operation
- `sig_in` passes through a 2-flop synchronizer. A rising-edge detector compares the second stage with a third flop. `edge` is a 1-cycle pulse.
- FSM states:
  - IDLE: `start` → ARM; `cnt` cleared.
  - ARM: waits for the first `edge`. On `edge` → MEASURE with `cnt` ← 0. If `cnt` reaches `MAX_PERIOD`−1 with no edge → DONE with `timeout`.
  - MEASURE: `cnt` increments every cycle. On `edge` → DONE with `period_out` ← `cnt`+1, so a signal with edges P cycles apart yields P. If `cnt` reaches `MAX_PERIOD`−1 → DONE with `timeout`.
  - DONE: `valid`=1 for one cycle, then → IDLE.
- Classification is computed in MEASURE→DONE from `cnt`+1. Code k matches when |P − nominal_k| ≤ `TOL`. Nominal values: 20, 100, 200, 1000. The lowest matching code wins. A timeout gives `match`=0.
- `period_out`, `timeout` and `match` hold their values until the next `valid`.
- `start` is ignored while `busy`=1 or in DONE.
- Arithmetic is unsigned. `cnt` saturates by construction through the timeout, so it never wraps.

## Timing
- Reset values: `busy`=0, `valid`=0, `period_out`=0, `timeout`=0, `match`=0, FSM=IDLE, synchronizer flops=0.
- Edge latency: 3 `clk` cycles from a `sig_in` rise to `edge`. This delay is common to both edges, so it cancels in P.
- `busy` rises 1 cycle after `start`.
- `valid` fires 1 cycle after the terminating edge or timeout.
- Minimum measurable P is 2. The same `edge` cannot both arm and terminate a measurement.
- An `edge` in the same cycle as the timeout compare counts as an edge. The edge has priority.
- `rst` asserted mid-measurement: all state returns to reset values immediately. No `valid` is produced.

## Configuration
- `CLK_PERIOD_METER_AVG_EN`:
  - Defined: MEASURE spans 4 consecutive periods (5 edges). A sum register of width CNT_W+2 accumulates them. `period_out` = sum >> 2 (truncating), and classification uses this average. The timeout limit applies per period.
  - Undefined: single-period measurement as described above. No sum register and no period counter.

## Structure
- Package `clk_meter_pkg` holds:
  - the FSM state enum `IDLE`/`ARM`/`MEASURE`/`DONE`;
  - `match` code constants `MATCH_NONE`…`MATCH_DIV500`;
  - nominal period constants 20/100/200/1000, derived as 2×divider.
- Sub-module `sync_edge_det` contains the 2-flop synchronizer and the rising-edge pulse. Its ports are `clk`, `rst`, `d`, `rise`.

## Test plan
- `sig_in` period 20 (10 high/10 low), `start` → `valid` with `period_out`=20, `match`=1, `timeout`=0.
- `sig_in` period 1000 → `period_out`=1000, `match`=4. With period 1003 and `TOL`=2 → `match`=0, `period_out`=1003.
- `sig_in` held 0, `start` → `valid` exactly `MAX_PERIOD`+1 cycles after `busy` rises, with `timeout`=1, `period_out`=0, `match`=0.
- `start` pulsed again while `busy` → ignored. Exactly one `valid`, and the result is unchanged.
- `rst` pulsed during MEASURE on a period-100 signal → outputs 0, no `valid`. A subsequent `start` → `period_out`=100, `match`=2.
- With `CLK_PERIOD_METER_AVG_EN` defined, periods 199,201,200,202 → `period_out`=200, `match`=3.

Source files
------------

// File: rtl/clk_period_meter_pkg.sv
// Shared types and constants for the clock period meter: FSM states, match codes,
// nominal divider periods and the period classifier.
package clk_meter_pkg;

  typedef enum logic [1:0] {IDLE, ARM, MEASURE, DONE} state_t;

  localparam logic [2:0] MATCH_NONE   = 3'd0;
  localparam logic [2:0] MATCH_DIV10  = 3'd1;
  localparam logic [2:0] MATCH_DIV50  = 3'd2;
  localparam logic [2:0] MATCH_DIV100 = 3'd3;
  localparam logic [2:0] MATCH_DIV500 = 3'd4;

  // A divide-by-N output toggles every N cycles, so one full period is 2*N.
  localparam int unsigned NOM_DIV10  = 2 * 10;
  localparam int unsigned NOM_DIV50  = 2 * 50;
  localparam int unsigned NOM_DIV100 = 2 * 100;
  localparam int unsigned NOM_DIV500 = 2 * 500;

  // Written as p + tol >= nom so nothing underflows in unsigned arithmetic.
  function automatic logic near(input int unsigned p, input int unsigned nom,
                                input int unsigned tol);
    return (p + tol >= nom) && (p <= nom + tol);
  endfunction

  function automatic logic [2:0] classify(input int unsigned p, input int unsigned tol);
    if (near(p, NOM_DIV10, tol))       return MATCH_DIV10;
    else if (near(p, NOM_DIV50, tol))  return MATCH_DIV50;
    else if (near(p, NOM_DIV100, tol)) return MATCH_DIV100;
    else if (near(p, NOM_DIV500, tol)) return MATCH_DIV500;
    else                               return MATCH_NONE;
  endfunction

endpackage

// File: rtl/clk_period_meter_sync_edge_det.sv
// Two-flop synchronizer for an asynchronous input followed by a rising-edge pulse.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic s1, s2, s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make this a true shift chain; blocking ones
      // would collapse all three stages into a single flop.
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/clk_period_meter.sv
// Measures the period of a slow asynchronous square wave in clk cycles and classifies it.
// Defining CLK_PERIOD_METER_AVG_EN averages four consecutive periods per measurement.
module clk_period_meter
  import clk_meter_pkg::*;
#(
  parameter int          CNT_W      = 16,
  parameter int unsigned MAX_PERIOD = 4096,
  parameter int unsigned TOL        = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             start,
  output logic             busy,
  output logic             valid,
  output logic [CNT_W-1:0] period_out,
  output logic             timeout,
  output logic [2:0]       match
);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next, cnt_inc, measured;
  logic             rise, at_limit, load, load_timeout;

`ifdef CLK_PERIOD_METER_AVG_EN
  logic [1:0]       per_cnt, per_cnt_next;
  logic [CNT_W+1:0] sum, sum_next, sum_total;

  assign sum_total = sum + {2'b00, cnt_inc};
  assign measured  = sum_total[CNT_W+1:2];
`else
  assign measured  = cnt_inc;
`endif

  sync_edge_det u_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (sig_in),
    .rise (rise)
  );

  assign cnt_inc  = cnt + CNT_W'(1);
  assign at_limit = (cnt == CNT_W'(MAX_PERIOD - 1));
  assign busy     = (state != IDLE);
  assign valid    = (state == DONE);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_next   = state;
    cnt_next     = cnt;
    load         = 1'b0;
    load_timeout = 1'b0;
`ifdef CLK_PERIOD_METER_AVG_EN
    sum_next     = sum;
    per_cnt_next = per_cnt;
`endif
    case (state)
      IDLE: begin
        cnt_next = '0;
`ifdef CLK_PERIOD_METER_AVG_EN
        sum_next     = '0;
        per_cnt_next = '0;
`endif
        if (start) state_next = ARM;
      end
      ARM: begin
        if (rise) begin
          state_next = MEASURE;
          cnt_next   = '0;
        end else if (at_limit) begin
          state_next   = DONE;
          load         = 1'b1;
          load_timeout = 1'b1;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      MEASURE: begin
        // An edge coinciding with the limit still completes the period.
        if (rise) begin
`ifdef CLK_PERIOD_METER_AVG_EN
          cnt_next     = '0;
          sum_next     = sum_total;
          per_cnt_next = per_cnt + 2'd1;
          if (per_cnt == 2'd3) begin
            state_next = DONE;
            load       = 1'b1;
          end
`else
          state_next = DONE;
          load       = 1'b1;
`endif
        end else if (at_limit) begin
          state_next   = DONE;
          load         = 1'b1;
          load_timeout = 1'b1;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
`ifdef CLK_PERIOD_METER_AVG_EN
      sum     <= '0;
      per_cnt <= '0;
`endif
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
`ifdef CLK_PERIOD_METER_AVG_EN
      sum     <= sum_next;
      per_cnt <= per_cnt_next;
`endif
    end
  end

  // Results are captured on entry to DONE so they appear together with valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_out <= '0;
      timeout    <= 1'b0;
      match      <= MATCH_NONE;
    end else if (load) begin
      period_out <= load_timeout ? '0 : measured;
      timeout    <= load_timeout;
      match      <= load_timeout ? MATCH_NONE : classify(32'(measured), TOL);
    end
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter; also covers averaging when CLK_PERIOD_METER_AVG_EN is defined.
module tb_clk_period_meter;

  localparam int MAX = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sig_in = 1'b0;
  logic        start = 1'b0;
  logic        busy, valid, timeout;
  logic [15:0] period_out;
  logic [2:0]  match;

  int vec_cnt  = 0;
  int miss_cnt = 0;
  int pers[4]  = '{20, 20, 20, 20};
  bit gen_on   = 1'b0;

  clk_period_meter dut (
    .clk        (clk),
    .rst        (rst),
    .sig_in     (sig_in),
    .start      (start),
    .busy       (busy),
    .valid      (valid),
    .period_out (period_out),
    .timeout    (timeout),
    .match      (match)
  );

  always #5 clk = ~clk;

  // Square-wave source cycling through pers[]; changes only on falling clk edges.
  initial begin
    forever begin
      if (gen_on) begin
        for (int k = 0; k < 4; k++) begin
          sig_in = 1'b1;
          repeat (pers[k] / 2) @(negedge clk);
          sig_in = 1'b0;
          repeat (pers[k] - pers[k] / 2) @(negedge clk);
        end
      end else begin
        sig_in = 1'b0;
        @(negedge clk);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_period(input int p0, input int p1, input int p2, input int p3);
    pers[0] = p0; pers[1] = p1; pers[2] = p2; pers[3] = p3;
    gen_on  = 1'b1;
    repeat (1100) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_valid(output bit got);
    int n;
    got = 1'b0;
    n   = 0;
    while (!got && n < 4 * MAX) begin
      @(posedge clk);
      #1;
      n++;
      if (valid) got = 1'b1;
    end
  endtask

  task automatic run_meas(input string tag, input int exp_p, input logic [2:0] exp_m);
    bit got;
    pulse_start();
    wait_valid(got);
    check({tag, "_valid"}, 32'(got), 1);
    check({tag, "_period"}, 32'(period_out), exp_p);
    check({tag, "_match"}, 32'(match), 32'(exp_m));
    check({tag, "_timeout"}, 32'(timeout), 0);
  endtask

  task automatic count_valids(input int cycles, output int nv);
    nv = 0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      if (valid) nv++;
    end
  endtask

  initial begin
    int  n, nv;
    bit  got;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_period", 32'(period_out), 0);
    check("rst_timeout", 32'(timeout), 0);
    check("rst_match", 32'(match), 0);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);

    // No edges at all: timeout after MAX+1 busy cycles including the valid cycle
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n   = 0;
    got = 1'b0;
    while (!got && n < 3 * MAX) begin
      if (busy) n++;
      if (valid) got = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check("to_valid", 32'(got), 1);
    check("to_cycles", n, MAX + 1);
    check("to_timeout", 32'(timeout), 1);
    check("to_period", 32'(period_out), 0);
    check("to_match", 32'(match), 0);

    // Nominal, tolerance-edge and out-of-tolerance periods
    set_period(20, 20, 20, 20);       run_meas("p20", 20, 3'd1);
    set_period(22, 22, 22, 22);       run_meas("p22", 22, 3'd1);
    set_period(23, 23, 23, 23);       run_meas("p23", 23, 3'd0);
    set_period(98, 98, 98, 98);       run_meas("p98", 98, 3'd2);
    set_period(200, 200, 200, 200);   run_meas("p200", 200, 3'd3);
    set_period(1000, 1000, 1000, 1000); run_meas("p1000", 1000, 3'd4);
    set_period(1003, 1003, 1003, 1003); run_meas("p1003", 1003, 3'd0);

    // Start while busy is ignored: one valid, result unchanged afterwards
    set_period(100, 100, 100, 100);
    pulse_start();
    repeat (50) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("ign_busy", 32'(busy), 1);
    wait_valid(got);
    check("ign_valid", 32'(got), 1);
    check("ign_period", 32'(period_out), 100);
    check("ign_match", 32'(match), 2);
    count_valids(1200, nv);
    check("ign_extra_valid", nv, 0);
    check("ign_period_hold", 32'(period_out), 100);

    // Reset mid-measurement clears everything and produces no valid
    @(posedge sig_in);
    pulse_start();
    repeat (60) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mrst_busy", 32'(busy), 0);
    check("mrst_valid", 32'(valid), 0);
    check("mrst_period", 32'(period_out), 0);
    check("mrst_match", 32'(match), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    count_valids(1200, nv);
    check("mrst_no_valid", nv, 0);
    run_meas("mrst_p100", 100, 3'd2);

`ifdef CLK_PERIOD_METER_AVG_EN
    // Four unequal periods summing to 802 average (truncated) to 200
    set_period(199, 201, 200, 202);
    run_meas("avg", 200, 3'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
